cp0_exc_ctrl: RTL

Coprocessor-0 exception controller for the P7 five-stage MIPS pipeline: the receiving end of the exception signals raised by the datapath, including the ALU arithmetic-overflow flag. It combines synchronous exception requests from the pipeline with six external hardware interrupts. On a taken exception or interrupt it latches SR/Cause/EPC, asserts the flush/redirect request, and later services `eret`, `mfc0` and `mtc0`.

---
 rtl/cp0_pkg.sv | 34 +++
 rtl/cp0_exc_ctrl_if.sv | 45 ++++
 rtl/cp0_int_arbiter.sv | 26 ++
 rtl/cp0_exc_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the P7 coprocessor-0 exception controller:
// CP0 register numbers, ExcCode values, SR/Cause field positions and the
// fixed PRId / exception-vector constants.
// Optional feature macro used by the importing files: CP0_BADVADDR_EN.
// -----------------------------------------------------------------------------
package cp0_pkg;

    typedef enum logic [4:0] {
        CP0_BADVADDR = 5'd8,
        CP0_SR       = 5'd12,
        CP0_CAUSE    = 5'd13,
        CP0_EPC      = 5'd14,
        CP0_PRID     = 5'd15
    } cp0_reg_e;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] PRID_VAL       = 32'h2018_0039;
    localparam logic [31:0] HANDLER_PC_VAL = 32'h0000_4180;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl_if
// Pipeline <-> CP0 bundle. The pipeline (master) presents the committing
// instruction's PC/BD/exception status, interrupt lines and mtc0/mfc0/eret
// requests; CP0 (slave) returns read data, EPC, the flush/redirect request,
// the handler address and the current EXL bit.
// badvaddr_i exists only when CP0_BADVADDR_EN is defined.
// -----------------------------------------------------------------------------
interface cp0_exc_ctrl_if;
    logic [31:0] pc_i;
    logic        bd_i;
    logic        exc_i;
    logic [4:0]  exc_code_i;
    logic [5:0]  hw_int_i;
    logic        we_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic        eret_i;
`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_i;
`endif
    logic [31:0] rdata_o;
    logic [31:0] epc_o;
    logic        int_req_o;
    logic [31:0] handler_pc_o;
    logic        exl_o;

    modport master (
        output pc_i, bd_i, exc_i, exc_code_i, hw_int_i,
               we_i, addr_i, wdata_i, eret_i,
`ifdef CP0_BADVADDR_EN
               badvaddr_i,
`endif
        input  rdata_o, epc_o, int_req_o, handler_pc_o, exl_o
    );

    modport slave (
        input  pc_i, bd_i, exc_i, exc_code_i, hw_int_i,
               we_i, addr_i, wdata_i, eret_i,
`ifdef CP0_BADVADDR_EN
               badvaddr_i,
`endif
        output rdata_o, epc_o, int_req_o, handler_pc_o, exl_o
    );
endinterface

// File: rtl/cp0_int_arbiter.sv
// -----------------------------------------------------------------------------
// cp0_int_arbiter
// Combinational request/priority logic. A request is raised when EXL is clear
// and either an enabled, unmasked interrupt line or a synchronous exception
// is pending. Interrupts take priority and record ExcCode 0.
// Ports: exl_i, ie_i, im_i[5:0], hw_int_i[5:0], exc_i, exc_code_i[4:0] in;
//        int_req_o, exc_code_o[4:0] out.
// -----------------------------------------------------------------------------
module cp0_int_arbiter
    import cp0_pkg::*;
(
    input  logic       exl_i,
    input  logic       ie_i,
    input  logic [5:0] im_i,
    input  logic [5:0] hw_int_i,
    input  logic       exc_i,
    input  logic [4:0] exc_code_i,
    output logic       int_req_o,
    output logic [4:0] exc_code_o
);
    logic int_pend;

    assign int_pend   = ie_i & (|(hw_int_i & im_i));
    assign int_req_o  = ~exl_i & (int_pend | exc_i);
    assign exc_code_o = int_pend ? EXC_INT : exc_code_i;
endmodule

// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
// Coprocessor-0 exception controller for the P7 pipeline. Holds SR, Cause,
// EPC (and optionally BadVAddr), raises the flush/redirect request on a taken
// exception or interrupt, and services mtc0 / mfc0 / eret.
// Ports: clk, reset (async, active-low), bus (cp0_exc_ctrl_if.slave).
// Optional feature: CP0_BADVADDR_EN adds register 8 (BadVAddr), loaded on a
// taken AdEL/AdES exception; without it address 8 reads 0.
// -----------------------------------------------------------------------------
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID       = PRID_VAL,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_VAL
) (
    input  logic                 clk,
    input  logic                 reset,
    cp0_exc_ctrl_if.slave        bus
);
    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q, badvaddr_d;
`endif

    logic        arb_req;
    logic [4:0]  sel_code;
    logic        take;
    logic        wr_sr;
    logic        wr_epc;

    cp0_int_arbiter u_arb (
        .exl_i      (sr_exl_q),
        .ie_i       (sr_ie_q),
        .im_i       (sr_im_q),
        .hw_int_i   (bus.hw_int_i),
        .exc_i      (bus.exc_i),
        .exc_code_i (bus.exc_code_i),
        .int_req_o  (arb_req),
        .exc_code_o (sel_code)
    );

    // Registers are already cleared while reset is low, but a synchronous
    // exception could still raise a request, so gate it explicitly.
    assign take   = arb_req & reset;
    assign wr_sr  = bus.we_i & ~take & (bus.addr_i == CP0_SR);
    assign wr_epc = bus.we_i & ~take & (bus.addr_i == CP0_EPC);

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_ie_d     = sr_ie_q;
        sr_exl_d    = sr_exl_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
`ifdef CP0_BADVADDR_EN
        badvaddr_d  = badvaddr_q;
`endif
        if (take) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = bus.bd_i;
            cause_exc_d = sel_code;
            epc_d       = bus.bd_i ? (bus.pc_i - 32'd4) : bus.pc_i;
`ifdef CP0_BADVADDR_EN
            // sel_code is 0 when an interrupt won, so this is sync-only.
            if (sel_code == EXC_ADEL || sel_code == EXC_ADES)
                badvaddr_d = bus.badvaddr_i;
`endif
        end else begin
            if (wr_sr) begin
                sr_im_d  = bus.wdata_i[SR_IM_LO +: 6];
                sr_ie_d  = bus.wdata_i[SR_IE];
                sr_exl_d = bus.wdata_i[SR_EXL];
            end
            // eret overrides an EXL value written by mtc0 in the same cycle.
            if (bus.eret_i)
                sr_exl_d = 1'b0;
            if (wr_epc)
                epc_d = bus.wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_q     <= '0;
            sr_ie_q     <= 1'b0;
            sr_exl_q    <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
`ifdef CP0_BADVADDR_EN
            badvaddr_q  <= '0;
`endif
        end else begin
            sr_im_q     <= sr_im_d;
            sr_ie_q     <= sr_ie_d;
            sr_exl_q    <= sr_exl_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= bus.hw_int_i;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
`ifdef CP0_BADVADDR_EN
            badvaddr_q  <= badvaddr_d;
`endif
        end
    end

    // mfc0 read of pre-edge register state.
    always_comb begin
        bus.rdata_o = '0;
        case (bus.addr_i)
            CP0_SR: begin
                bus.rdata_o[SR_IM_LO +: 6] = sr_im_q;
                bus.rdata_o[SR_EXL]        = sr_exl_q;
                bus.rdata_o[SR_IE]         = sr_ie_q;
            end
            CP0_CAUSE: begin
                bus.rdata_o[CAUSE_BD]            = cause_bd_q;
                bus.rdata_o[CAUSE_IP_LO +: 6]    = cause_ip_q;
                bus.rdata_o[CAUSE_EXC_LO +: 5]   = cause_exc_q;
            end
            CP0_EPC:      bus.rdata_o = epc_q;
            CP0_PRID:     bus.rdata_o = PRID;
`ifdef CP0_BADVADDR_EN
            CP0_BADVADDR: bus.rdata_o = badvaddr_q;
`endif
            default:      bus.rdata_o = '0;
        endcase
    end

    // Bypass lets an eret directly after an mtc0 EPC use the new value.
    assign bus.epc_o        = !reset ? 32'd0 :
                              (bus.we_i && bus.addr_i == CP0_EPC) ? bus.wdata_i : epc_q;
    assign bus.int_req_o    = take;
    assign bus.handler_pc_o = HANDLER_PC;
    assign bus.exl_o        = sr_exl_q;
endmodule
